// File: rtl/alu_pkg.sv
// Shared definitions for the registered multi-cycle ALU: op codes, FSM states
// and the helper that tells single-cycle ops from iterative ones.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'b0000,
    OP_SLL   = 4'b0001,
    OP_SUB   = 4'b0010,
    OP_SLT   = 4'b0011,
    OP_XOR   = 4'b0100,
    OP_SRL   = 4'b0101,
    OP_OR    = 4'b0110,
    OP_AND   = 4'b0111,
    OP_SRA   = 4'b1000,
    OP_SLTU  = 4'b1001,
    OP_MUL   = 4'b1010,
    OP_MULHU = 4'b1011,
    OP_DIV   = 4'b1100,
    OP_DIVU  = 4'b1101,
    OP_REM   = 4'b1110,
    OP_REMU  = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  // MUL, MULHU and the four divide/remainder ops occupy codes 1010..1111.
  function automatic logic is_multicycle(input alu_op_e op);
    return op[3] & (op[2] | op[1]);
  endfunction

  function automatic logic is_div_op(input alu_op_e op);
    return op[3] & op[2];
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative datapath: shift-add multiply or restoring divide on magnitudes,
// one bit per cycle, with sign correction folded into the final iteration.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  alu_op_e          op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH);

  logic             active_q, active_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic             is_div_q, is_div_d, sel_hi_q, sel_hi_d, neg_res_q, neg_res_d;

  logic [WIDTH:0]   sum, shifted, diff;
  logic [WIDTH-1:0] hi_step, lo_step, raw;
  logic             is_div, sdiv, neg_a, neg_b;

  // hi holds the running product high half / partial remainder; lo holds the
  // multiplier / dividend bits that shift out as quotient bits shift in.
  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    shifted = {hi_q, lo_q[WIDTH-1]};
    diff    = shifted - {1'b0, b_q};
    if (is_div_q) begin
      hi_step = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      lo_step = {lo_q[WIDTH-2:0], ~diff[WIDTH]};
    end else begin
      hi_step = sum[WIDTH:1];
      lo_step = {sum[0], lo_q[WIDTH-1:1]};
    end
    raw      = sel_hi_q ? hi_step : lo_step;
    result_o = neg_res_q ? -raw : raw;
    done_o   = active_q && (cnt_q == CW'(WIDTH - 1));
  end

  always_comb begin
    is_div = is_div_op(op_i);
    sdiv   = is_div & ~op_i[0];
    neg_a  = sdiv & a_i[WIDTH-1];
    neg_b  = sdiv & b_i[WIDTH-1];

    // NOTE: every always_comb output gets a hold/default value first so no path leaves it unassigned and infers a latch.
    active_d  = active_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    b_d       = b_q;
    is_div_d  = is_div_q;
    sel_hi_d  = sel_hi_q;
    neg_res_d = neg_res_q;

    if (abort_i) begin
      active_d = 1'b0;
    end else if (start_i) begin
      active_d  = 1'b1;
      cnt_d     = '0;
      hi_d      = '0;
      lo_d      = (neg_a) ? -a_i : a_i;
      b_d       = (neg_b) ? -b_i : b_i;
      is_div_d  = is_div;
      sel_hi_d  = is_div ? op_i[1] : op_i[0];
      neg_res_d = sdiv & (op_i[1] ? neg_a : (neg_a ^ neg_b));
    end else if (active_q) begin
      hi_d  = hi_step;
      lo_d  = lo_step;
      cnt_d = cnt_q + 1'b1;
      if (done_o) active_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q  <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      b_q       <= '0;
      is_div_q  <= 1'b0;
      sel_hi_q  <= 1'b0;
      neg_res_q <= 1'b0;
    end else begin
      active_q  <= active_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      b_q       <= b_d;
      is_div_q  <= is_div_d;
      sel_hi_q  <= sel_hi_d;
      neg_res_q <= neg_res_d;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Registered RV32I/M ALU with valid/ready handshakes: single-cycle ops and
// divide special cases finish in one cycle, mul/div iterate for WIDTH cycles.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [3:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             zero,
  output logic             sign_flag
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, sign_q, sign_d;

  alu_op_e          op;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] single_res, special_res, iter_res;
  logic             b_zero, div_ovf, special, iter_start, iter_done;

  assign op    = alu_op_e'(ALUControl);
  assign shamt = SrcB[SHW-1:0];

  always_comb begin
    single_res = '0;
    case (op)
      OP_ADD:  single_res = SrcA + SrcB;
      OP_SUB:  single_res = SrcA - SrcB;
      OP_SLL:  single_res = SrcA << shamt;
      OP_SRL:  single_res = SrcA >> shamt;
      OP_SRA:  single_res = $unsigned($signed(SrcA) >>> shamt);
      OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
      OP_SLTU: single_res = {{(WIDTH-1){1'b0}}, SrcA < SrcB};
      OP_XOR:  single_res = SrcA ^ SrcB;
      OP_OR:   single_res = SrcA | SrcB;
      OP_AND:  single_res = SrcA & SrcB;
      default: single_res = '0;
    endcase
  end

  // Divide-by-zero and MIN/-1 are resolved here and never reach the iterator.
  always_comb begin
    b_zero  = (SrcB == '0);
    div_ovf = ~op[0] && (SrcA == {1'b1, {(WIDTH-1){1'b0}}}) && (SrcB == '1);
    special = is_div_op(op) && (b_zero || div_ovf);
    if (b_zero) special_res = op[1] ? SrcA : '1;
    else        special_res = op[1] ? '0 : SrcA;
  end

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    zero_d     = zero_q;
    sign_d     = sign_q;
    iter_start = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!flush && in_valid) begin
          if (is_multicycle(op) && !special) begin
            iter_start = 1'b1;
            state_d    = ST_BUSY;
          end else begin
            result_d = special ? special_res : single_res;
            state_d  = ST_DONE;
          end
        end
      end
      ST_BUSY: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (iter_done) begin
          result_d = iter_res;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (flush || out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Flags follow the registered result; they only change on entry to DONE.
    if (state_d == ST_DONE && state_q != ST_DONE) begin
      zero_d = (result_d == '0);
      sign_d = result_d[WIDTH-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      sign_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      sign_q   <= sign_d;
    end
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst      (rst),
    .start_i  (iter_start),
    .abort_i  (flush),
    .op_i     (op),
    .a_i      (SrcA),
    .b_i      (SrcB),
    .done_o   (iter_done),
    .result_o (iter_res)
  );

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = (state_q == ST_DONE);
  assign ALUResult = result_q;
  assign zero      = zero_q;
  assign sign_flag = sign_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc: results, flags, latency, backpressure,
// flush and asynchronous reset behaviour.
module tb_alu_mc;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, zero, sign_flag;
  logic [31:0] SrcA, SrcB, ALUResult;
  logic [3:0]  ALUControl;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .ALUControl (ALUControl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALUResult  (ALUResult),
    .zero       (zero),
    .sign_flag  (sign_flag)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op, measure accept-to-out_valid latency, check result and flags,
  // then complete the output handshake.
  task automatic run_op(input string tag, input alu_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    logic rdy_busy;
    @(negedge clk);
    check({tag, ".in_ready"}, in_ready, 1);
    ALUControl = op; SrcA = a; SrcB = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; SrcA = $urandom; SrcB = $urandom; ALUControl = 4'($urandom);
    lat = 1;
    rdy_busy = 1'b0;
    while (!out_valid && lat < 100) begin
      rdy_busy |= in_ready;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".res"}, ALUResult, exp);
    check({tag, ".zero"}, zero, (exp == 32'h0));
    check({tag, ".sign"}, sign_flag, exp[31]);
    if (exp_lat > 1) check({tag, ".in_ready_busy"}, rdy_busy, 0);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    check({tag, ".released"}, out_valid, 0);
  endtask

  task automatic watch_no_valid(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    check(tag, seen, 0);
  endtask

  initial begin
    logic [31:0] held;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    SrcA = '0; SrcB = '0; ALUControl = '0;
    #12;
    check("rst.out_valid", out_valid, 0);
    check("rst.result", ALUResult, 0);
    check("rst.zero", zero, 0);
    check("rst.sign", sign_flag, 0);
    check("rst.in_ready", in_ready, 0);
    @(negedge clk); rst = 1'b0; #1;
    check("rst.release_ready", in_ready, 1);

    run_op("add_wrap", OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1);
    run_op("sub_zero", OP_SUB,  32'd5,        32'd5,        32'h00000000, 1);
    run_op("sra",      OP_SRA,  32'h80000000, 32'h00000021, 32'hC0000000, 1);
    run_op("srl",      OP_SRL,  32'h80000000, 32'h00000021, 32'h40000000, 1);
    run_op("sll31",    OP_SLL,  32'h00000001, 32'h0000003F, 32'h80000000, 1);
    run_op("sltu",     OP_SLTU, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1);
    run_op("slt",      OP_SLT,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1);
    run_op("xor",      OP_XOR,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 1);
    run_op("or",       OP_OR,   32'hA000_0005, 32'h0500_0050, 32'hA500_0055, 1);
    run_op("and",      OP_AND,  32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1);
    run_op("mul",      OP_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33);
    run_op("mulhu",    OP_MULHU,32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op("mul_small",OP_MUL,  32'd1234,     32'd5678,     32'd7006652,  33);
    run_op("div_neg",  OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run_op("rem_neg",  OP_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run_op("divu",     OP_DIVU, 32'd100,      32'd7,        32'd14,       33);
    run_op("remu",     OP_REMU, 32'd100,      32'd7,        32'd2,        33);
    run_op("div_bneg", OP_DIV,  32'd20,       32'hFFFFFFFA, 32'hFFFFFFFD, 33);
    run_op("divu_z",   OP_DIVU, 32'd7,        32'd0,        32'hFFFFFFFF, 1);
    run_op("remu_z",   OP_REMU, 32'd7,        32'd0,        32'd7,        1);
    run_op("div_ovf",  OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ovf",  OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

    // Backpressure: result held in DONE for 5 cycles
    @(negedge clk);
    ALUControl = OP_ADD; SrcA = 32'h1234_0000; SrcB = 32'h0000_5678; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    held = ALUResult;
    check("bp.first", held, 32'h1234_5678);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp.stable", ALUResult, held);
      check("bp.valid", out_valid, 1);
      check("bp.in_ready", in_ready, 0);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    check("bp.idle_valid", out_valid, 0);
    check("bp.idle_ready", in_ready, 1);
    run_op("bp.next", OP_SUB, 32'd3, 32'd10, 32'hFFFFFFF9, 1);

    // flush beats a same-cycle accept in IDLE
    @(negedge clk);
    ALUControl = OP_ADD; SrcA = 32'd1; SrcB = 32'd1; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0; flush = 1'b0;
    check("flush_idle.valid", out_valid, 0);
    check("flush_idle.ready", in_ready, 1);

    // flush during BUSY iteration 10
    @(negedge clk);
    ALUControl = OP_MUL; SrcA = 32'd3; SrcB = 32'd4; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    for (int i = 0; i < 10; i++) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    check("flush_busy.ready", in_ready, 1);
    check("flush_busy.valid", out_valid, 0);
    watch_no_valid("flush_busy.no_result", 40);
    run_op("after_flush", OP_MUL, 32'd3, 32'd4, 32'd12, 33);

    // async reset mid-BUSY, with a nonzero result still registered
    @(negedge clk);
    ALUControl = OP_DIVU; SrcA = 32'd50; SrcB = 32'd5; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    for (int i = 0; i < 5; i++) @(posedge clk);
    #2; rst = 1'b1; #1;
    check("rst_busy.result", ALUResult, 0);
    check("rst_busy.valid", out_valid, 0);
    check("rst_busy.sign", sign_flag, 0);
    check("rst_busy.ready", in_ready, 0);
    @(negedge clk); rst = 1'b0; #1;
    check("rst_busy.release", in_ready, 1);
    watch_no_valid("rst_busy.no_result", 40);
    run_op("after_rst", OP_DIVU, 32'd50, 32'd5, 32'd10, 33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
